// File: rtl/alu_result_checker.sv
// alu_result_checker: response-side checker for the 4-bit ALU self-test loop.
// Every applied operand/select vector is run through a reference model and
// carried down a LAT-deep expected-result pipeline. When it emerges, it is
// compared against the DUT's y/z. The checker keeps saturating pass/error
// statistics and captures the first failing vector of each run.
// Optional build macro: ALU_CHK_STOP_ON_ERR_EN - the first mismatch ends the run
// (goes straight to DONE) and discards the remaining in-flight entries.
`timescale 1ns/1ps

module alu_result_checker #(
    parameter int LAT = 1,
    parameter int CW  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          stim_valid,
    input  logic [3:0]    stim_a,
    input  logic [3:0]    stim_b,
    input  logic          stim_c0,
    input  logic          stim_c1,
    input  logic [3:0]    dut_y,
    input  logic [3:0]    dut_z,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          err_sticky,
    output logic [CW-1:0] check_cnt,
    output logic [CW-1:0] err_cnt,
    output logic [9:0]    first_err_vec,
    output logic [7:0]    first_err_got
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    // Reference ALU: {y, z}. For the add, z[i] is the carry out of bit i.
    function automatic logic [7:0] alu_ref(input logic [1:0] op,
                                           input logic [3:0] a,
                                           input logic [3:0] b);
        logic [3:0] y;
        logic [3:0] z;
        logic       k;
        y = '0;
        z = '0;
        k = 1'b0;
        case (op)
            2'b00:   y = a & b;
            2'b01:   y = a | b;
            2'b10:   y = a ^ b;
            default: begin
                for (int i = 0; i < 4; i++) begin
                    y[i] = a[i] ^ b[i] ^ k;
                    z[i] = (a[i] & b[i]) | (a[i] & k) | (b[i] & k);
                    k    = z[i];
                end
            end
        endcase
        return {y, z};
    endfunction

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    state_t        r_state;
    state_t        w_nxt;
    logic          w_active;
    logic          w_in_vld;
    logic [7:0]    w_in_exp;
    logic [9:0]    w_in_vec;
    logic          w_cmp_vld;
    logic [7:0]    w_cmp_exp;
    logic [9:0]    w_cmp_vec;
    logic          w_pipe_empty;
    logic          w_cmp;
    logic          w_mis;
    logic          w_abort;
    logic          w_clr;
    logic          w_flush_pipe;

    logic          r_err_sticky;
    logic [CW-1:0] r_check_cnt;
    logic [CW-1:0] r_err_cnt;
    logic [9:0]    r_first_err_vec;
    logic [7:0]    r_first_err_got;

    assign w_active = (r_state == S_RUN) || (r_state == S_FLUSH);
    assign w_in_vld = (r_state == S_RUN) && stim_valid;
    assign w_in_exp = alu_ref({stim_c1, stim_c0}, stim_a, stim_b);
    assign w_in_vec = {stim_c1, stim_c0, stim_a, stim_b};

    generate
        if (LAT == 0) begin : g_lat0
            assign w_cmp_vld    = w_in_vld;
            assign w_cmp_exp    = w_in_exp;
            assign w_cmp_vec    = w_in_vec;
            assign w_pipe_empty = 1'b1;
        end else begin : g_pipe
            logic [LAT-1:0] r_vld_p;
            logic [7:0]     r_exp_p [LAT];
            logic [9:0]     r_vec_p [LAT];

            // Valid bits of the expected-result pipeline; dropped outside an active run or on abort
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld_p <= '0;
                end else if (w_flush_pipe) begin
                    r_vld_p <= '0;
                end else begin
                    r_vld_p[0] <= w_in_vld;
                    for (int i = 1; i < LAT; i++) r_vld_p[i] <= r_vld_p[i-1];
                end
            end

            // Expected {y,z} and vector payload travel beside the valids, no reset needed
            always_ff @(posedge clk) begin
                r_exp_p[0] <= w_in_exp;
                r_vec_p[0] <= w_in_vec;
                for (int i = 1; i < LAT; i++) begin
                    r_exp_p[i] <= r_exp_p[i-1];
                    r_vec_p[i] <= r_vec_p[i-1];
                end
            end

            assign w_cmp_vld    = r_vld_p[LAT-1];
            assign w_cmp_exp    = r_exp_p[LAT-1];
            assign w_cmp_vec    = r_vec_p[LAT-1];
            assign w_pipe_empty = ~|r_vld_p;
        end
    endgenerate

    assign w_cmp = w_cmp_vld && w_active;
    assign w_mis = w_cmp && ({dut_y, dut_z} != w_cmp_exp);

`ifdef ALU_CHK_STOP_ON_ERR_EN
    assign w_abort = w_mis;
`else
    assign w_abort = 1'b0;
`endif

    assign w_flush_pipe = w_abort || !w_active;
    assign w_clr        = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nxt;
    end

    // Next-state logic; stop has priority over start while running
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)        w_nxt = S_RUN;
            S_RUN:   if (stop)         w_nxt = S_FLUSH;
            S_FLUSH: if (w_pipe_empty) w_nxt = S_DONE;
            S_DONE:  if (start)        w_nxt = S_RUN;
            default:                   w_nxt = S_IDLE;
        endcase
        if (w_abort) w_nxt = S_DONE;
    end

    // Status outputs decoded from the state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        pass = 1'b0;
        case (r_state)
            S_RUN, S_FLUSH: busy = 1'b1;
            S_DONE: begin
                done = 1'b1;
                pass = (r_err_cnt == '0);
            end
            default: ;
        endcase
    end

    // Run statistics: cleared by start, updated on each comparison, first failure captured once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_check_cnt     <= '0;
            r_err_cnt       <= '0;
            r_err_sticky    <= 1'b0;
            r_first_err_vec <= '0;
            r_first_err_got <= '0;
        end else if (w_clr) begin
            r_check_cnt     <= '0;
            r_err_cnt       <= '0;
            r_err_sticky    <= 1'b0;
            r_first_err_vec <= '0;
            r_first_err_got <= '0;
        end else if (w_cmp) begin
            r_check_cnt <= sat_inc(r_check_cnt);
            if (w_mis) begin
                r_err_cnt    <= sat_inc(r_err_cnt);
                r_err_sticky <= 1'b1;
                if (!r_err_sticky) begin
                    r_first_err_vec <= w_cmp_vec;
                    r_first_err_got <= {dut_y, dut_z};
                end
            end
        end
    end

    assign err_sticky    = r_err_sticky;
    assign check_cnt     = r_check_cnt;
    assign err_cnt       = r_err_cnt;
    assign first_err_vec = r_first_err_vec;
    assign first_err_got = r_first_err_got;

endmodule

// File: tb/tb_alu_result_checker.sv
// tb_alu_result_checker: drives vectors into alu_result_checker while a
// behavioural ALU with a LAT-cycle delay line returns y/z (optionally corrupted).
// A scoreboard queue holds each accepted vector's expected outcome and is popped
// whenever the checker reports a new comparison.
`timescale 1ns/1ps

module tb_alu_result_checker;

    localparam int TB_LAT = 3;
    localparam int TB_CW  = 4;
    localparam int MAXC   = (1 << TB_CW) - 1;
`ifdef ALU_CHK_STOP_ON_ERR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             stop;
    logic             stim_valid;
    logic [3:0]       stim_a;
    logic [3:0]       stim_b;
    logic             stim_c0;
    logic             stim_c1;
    logic [3:0]       dut_y;
    logic [3:0]       dut_z;
    logic             busy;
    logic             done;
    logic             pass;
    logic             err_sticky;
    logic [TB_CW-1:0] check_cnt;
    logic [TB_CW-1:0] err_cnt;
    logic [9:0]       first_err_vec;
    logic [7:0]       first_err_got;

    logic             corrupt;
    logic [7:0]       w_alu0;
    logic [7:0]       dly [1:TB_LAT];

    typedef struct {
        logic       bad;
        logic [9:0] vec;
        logic [7:0] got;
    } sb_t;

    sb_t sb_q[$];
    int  sb_chk;
    int  sb_err;
    bit  in_run;
    int  n_tests;
    int  n_fail;
    int  n_cyc;
    logic [1:0] r_op;
    logic [3:0] r_a;
    logic [3:0] r_b;

    always #5 clk = ~clk;

    alu_result_checker #(.LAT(TB_LAT), .CW(TB_CW)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stop          (stop),
        .stim_valid    (stim_valid),
        .stim_a        (stim_a),
        .stim_b        (stim_b),
        .stim_c0       (stim_c0),
        .stim_c1       (stim_c1),
        .dut_y         (dut_y),
        .dut_z         (dut_z),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_sticky    (err_sticky),
        .check_cnt     (check_cnt),
        .err_cnt       (err_cnt),
        .first_err_vec (first_err_vec),
        .first_err_got (first_err_got)
    );

    // Behavioural ALU: add built from integer sums of the low bits
    function automatic logic [7:0] tb_alu(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int sa;
        int sm;
        int m;
        logic [3:0] y;
        logic [3:0] z;
        z = '0;
        case (op)
            2'd0:    y = a & b;
            2'd1:    y = a | b;
            2'd2:    y = a ^ b;
            default: begin
                sa = int'(a) + int'(b);
                y  = sa[3:0];
                for (int i = 0; i < 4; i++) begin
                    m    = (2 << i) - 1;
                    sm   = (int'(a) & m) + (int'(b) & m);
                    z[i] = sm[i+1];
                end
            end
        endcase
        return {y, z};
    endfunction

    always_comb w_alu0 = tb_alu({stim_c1, stim_c0}, stim_a, stim_b) ^ (corrupt ? 8'h10 : 8'h00);

    always @(posedge clk) begin
        dly[1] <= w_alu0;
        for (int i = 2; i <= TB_LAT; i++) dly[i] <= dly[i-1];
    end

    assign dut_y = dly[TB_LAT][7:4];
    assign dut_z = dly[TB_LAT][3:0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_clear();
        sb_q.delete();
        sb_chk = 0;
        sb_err = 0;
    endtask

    // One clock; outputs sampled 1ns after the edge and scoreboard updated
    task automatic step();
        sb_t e;
        @(posedge clk);
        #1;
        if (32'(check_cnt) != sb_chk) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_check", 32'(check_cnt), sb_chk);
            end else begin
                e = sb_q.pop_front();
                if (sb_chk < MAXC) sb_chk++;
                if (e.bad && sb_err < MAXC) begin
                    if (sb_err == 0) begin
                        chk("sb_first_err_vec", 32'(first_err_vec), 32'(e.vec));
                        chk("sb_first_err_got", 32'(first_err_got), 32'(e.got));
                    end
                    sb_err++;
                end
                chk("sb_check_cnt", 32'(check_cnt), sb_chk);
                chk("sb_err_cnt", 32'(err_cnt), sb_err);
            end
        end
    endtask

    task automatic vec(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b, input logic bad);
        sb_t e;
        stim_valid = 1'b1;
        {stim_c1, stim_c0} = op;
        stim_a  = a;
        stim_b  = b;
        corrupt = bad;
        if (in_run) begin
            e.bad = bad;
            e.vec = {op, a, b};
            e.got = tb_alu(op, a, b) ^ (bad ? 8'h10 : 8'h00);
            sb_q.push_back(e);
        end
        step();
    endtask

    task automatic idle(input int n);
        stim_valid = 1'b0;
        corrupt    = 1'b0;
        repeat (n) step();
    endtask

    task automatic start_run();
        start = 1'b1;
        sb_clear();
        in_run = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic stop_run();
        stim_valid = 1'b0;
        corrupt    = 1'b0;
        stop       = 1'b1;
        step();
        stop   = 1'b0;
        in_run = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("done_reached", 32'(done), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_pass"},  32'(pass), 32'd0);
        chk({tag, "_stats"}, 32'({err_sticky, check_cnt, err_cnt}), 32'd0);
        chk({tag, "_first"}, 32'({first_err_vec, first_err_got}), 32'd0);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; stop = 1'b0; stim_valid = 1'b0;
        stim_a = '0; stim_b = '0; stim_c0 = 1'b0; stim_c1 = 1'b0; corrupt = 1'b0;
        n_tests = 0; n_fail = 0; in_run = 1'b0;
        sb_clear();
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Run A: correct DUT, all four ops
        start_run();
        chk("runA_busy", 32'(busy), 32'd1);
        vec(2'b00, 4'b1101, 4'b1110, 1'b0);
        vec(2'b01, 4'b1101, 4'b1110, 1'b0);
        vec(2'b10, 4'b1101, 4'b1110, 1'b0);
        vec(2'b11, 4'b1101, 4'b1110, 1'b0);
        stop_run();
        wait_done(n_cyc);
        chk("runA_check_cnt", 32'(check_cnt), 32'd4);
        chk("runA_err_cnt", 32'(err_cnt), 32'd0);
        chk("runA_pass", 32'(pass), 32'd1);
        chk("runA_busy_low", 32'(busy), 32'd0);

        // Run B: ADD result corrupted, stop right after the last vector
        start_run();
        chk("runB_cleared_cnt", 32'(check_cnt), 32'd0);
        vec(2'b00, 4'b1101, 4'b1110, 1'b0);
        vec(2'b01, 4'b1101, 4'b1110, 1'b0);
        vec(2'b10, 4'b1101, 4'b1110, 1'b0);
        vec(2'b11, 4'b1101, 4'b1110, 1'b1);
        stop_run();
        wait_done(n_cyc);
        chk("runB_flush_cycles", 32'(n_cyc), STOP_ON_ERR ? 32'(TB_LAT - 1) : 32'(TB_LAT));
        chk("runB_check_cnt", 32'(check_cnt), 32'd4);
        chk("runB_err_cnt", 32'(err_cnt), 32'd1);
        chk("runB_sticky", 32'(err_sticky), 32'd1);
        chk("runB_pass", 32'(pass), 32'd0);
        chk("runB_first_vec", 32'(first_err_vec), 32'b11_1101_1110);
        chk("runB_first_got", 32'(first_err_got), 32'b1010_1100);

        // Run C: start in DONE clears; two bad vectors
        start_run();
        chk("runC_clr_err", 32'(err_cnt), 32'd0);
        chk("runC_clr_sticky", 32'(err_sticky), 32'd0);
        chk("runC_clr_first", 32'({first_err_vec, first_err_got}), 32'd0);
        vec(2'b11, 4'b0101, 4'b0011, 1'b1);
        vec(2'b00, 4'b1111, 4'b1111, 1'b1);
        idle(TB_LAT);
        if (STOP_ON_ERR) begin
            chk("runC_abort_done", 32'(done), 32'd1);
            chk("runC_abort_err", 32'(err_cnt), 32'd1);
            chk("runC_abort_chk", 32'(check_cnt), 32'd1);
            chk("runC_abort_pass", 32'(pass), 32'd0);
        end else begin
            chk("runC_err_cnt", 32'(err_cnt), 32'd2);
            start = 1'b1;
            stop  = 1'b1;
            step();
            start = 1'b0;
            stop  = 1'b0;
            in_run = 1'b0;
            chk("runC_flush_busy", 32'(busy), 32'd1);
            chk("runC_flush_done", 32'(done), 32'd0);
            chk("runC_flush_err", 32'(err_cnt), 32'd2);
        end
        #1 rst_n = 1'b0;
        in_run = 1'b0;
        sb_clear();
        #1;
        chk_all_zero("midreset");
        rst_n = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);

        // stim_valid outside RUN is ignored
        vec(2'b11, 4'b1111, 4'b0001, 1'b1);
        vec(2'b01, 4'b0000, 4'b0000, 1'b1);
        idle(TB_LAT + 2);
        chk("idle_no_check", 32'(check_cnt), 32'd0);

        // Run D: clean run after reset, random vectors
        start_run();
        for (int i = 0; i < 3; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = 4'($urandom_range(0, 15));
            r_b  = 4'($urandom_range(0, 15));
            vec(r_op, r_a, r_b, 1'b0);
        end
        stop_run();
        wait_done(n_cyc);
        chk("runD_check_cnt", 32'(check_cnt), 32'd3);
        chk("runD_err_cnt", 32'(err_cnt), 32'd0);
        chk("runD_pass", 32'(pass), 32'd1);

        // Run E: counters saturate at all-ones
        start_run();
        for (int i = 0; i < MAXC + 3; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = 4'($urandom_range(0, 15));
            r_b  = 4'($urandom_range(0, 15));
            vec(r_op, r_a, r_b, !STOP_ON_ERR);
        end
        stop_run();
        wait_done(n_cyc);
        chk("runE_check_sat", 32'(check_cnt), 32'(MAXC));
        chk("runE_err_sat", 32'(err_cnt), STOP_ON_ERR ? 32'd0 : 32'(MAXC));
        chk("runE_sticky", 32'(err_sticky), STOP_ON_ERR ? 32'd0 : 32'd1);
        chk("runE_pass", 32'(pass), STOP_ON_ERR ? 32'd1 : 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_checker.md
Name: alu_result_checker

Overview:
Response-side counterpart to the 4-bit ALU stimulus source. It accepts each applied operand/select vector and the DUT's returned y/z after a fixed latency, and compares them against an internal reference model. It keeps pass/error statistics and captures the first failing vector. It sits beside fourALU1Bit in simulation and FPGA self-test builds, and closes the stimulus -> DUT -> check loop.

Parameters:
LAT, 1, DUT result latency in clock cycles between stim_valid and the matching dut_y/dut_z (legal 0..7).
CW, 16, width of the check and error counters.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; clears statistics and begins a run.
stop  in  1  one-cycle pulse; ends stimulus acceptance and drains the pipeline.
stim_valid  in  1  stim_* holds a vector applied to the DUT this cycle.
stim_a  in  4  operand a.
stim_b  in  4  operand b.
stim_c0  in  1  select bit 0.
stim_c1  in  1  select bit 1.
dut_y  in  4  DUT result, valid LAT cycles after the stimulus.
dut_z  in  4  DUT per-bit carry, valid LAT cycles after the stimulus.
busy  out  1  high in RUN or FLUSH.
done  out  1  high in DONE.
pass  out  1  in DONE, high when err_cnt==0; otherwise 0.
err_sticky  out  1  set on any mismatch; cleared only by start or reset.
check_cnt  out  CW  number of comparisons performed.
err_cnt  out  CW  number of mismatching comparisons.
first_err_vec  out  10  {c1,c0,a[3:0],b[3:0]} of the first mismatch.
first_err_got  out  8  {y,z} returned by the DUT on the first mismatch.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; expected pipeline valids cleared.
- Reference model, op={c1,c0}:
  - 00: y=a&b, z=0.
  - 01: y=a|b, z=0.
  - 10: y=a^b, z=0.
  - 11: ripple add with carry-in 0. y[i]=a[i]^b[i]^k[i], z[i]=carry out of bit i, k[0]=0, k[i]=z[i-1].
- Expected pipeline: LAT stages of {valid, exp_y, exp_z, vec}. With LAT=0 the comparison uses stim_* and dut_* in the same cycle.
- Compare on the cycle the delayed valid emerges:
  - check_cnt increments.
  - On mismatch, err_cnt increments and err_sticky is set.
  - On the first mismatch of a run, first_err_vec and first_err_got are latched.
  - Both counters saturate at all-ones.
- FSM:
  - IDLE: start -> RUN.
  - RUN: stim_valid vectors enter the pipeline. stop -> FLUSH.
  - FLUSH: stim_valid is ignored. Moves to DONE on the cycle after the pipeline holds no valid entries (LAT=0: next cycle).
  - DONE: holds results. start -> RUN.
- start in IDLE or DONE clears counters, err_sticky and first_err_* in the same edge that enters RUN.
- start in RUN or FLUSH is ignored.
- start and stop in the same RUN cycle: stop wins.
- stim_valid is ignored outside RUN.
- Entries already in flight at stop are still checked.
- Reset mid-run discards the pipeline and statistics immediately.

Optional Feature:
ALU_CHK_STOP_ON_ERR_EN:
- When defined, the first mismatch forces the next state to DONE directly from RUN or FLUSH. Remaining pipeline entries are discarded and not counted, and pass=0.
- When undefined, checking continues to the end of the run as described above.

Test Plan:
- LAT=1, start; a=1101 b=1110, op 00/01/10/11 with a correct DUT model; stop -> check_cnt=4, err_cnt=0, pass=1 in DONE. Expected y/z: 00 -> 1100/0000; 01 -> 1111/0000; 10 -> 0011/0000; 11 -> 1011/1100.
- Same run with dut_y corrupted to 1010 on the ADD vector -> err_cnt=1, err_sticky=1, pass=0, first_err_vec=11_1101_1110, first_err_got=1010_1100.
- Assert stop the cycle after the last stim_valid with LAT=3 -> DONE not before 4 cycles after stop; all 3 in-flight vectors counted.
- Pulse rst_n low during FLUSH with err_cnt=2 -> all outputs 0 immediately, state IDLE; a subsequent start gives a clean run.
- start and stop in the same RUN cycle -> enters FLUSH; start pulse in DONE clears err_cnt and err_sticky to 0.
- With ALU_CHK_STOP_ON_ERR_EN, two consecutive bad vectors -> DONE after the first; err_cnt=1.
